phase_timer_ctrl: RTL and testbench

//   Timing sequencer for the traffic-light phase FSM. Watches the FSM one-hot phase
//   (fsm_g/fsm_y/fsm_r) and loads a per-phase duration in seconds. It counts that

---
 rtl/phase_timer_ctrl.sv | 137 +++++++++++++
 tb/tb_phase_timer_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/phase_timer_ctrl.sv
// Phase duration sequencer: loads a per-phase time on each FSM phase change,
// counts it down in prescaled seconds and pulses the matching end strobe.
module phase_timer_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 7,
  parameter int G_DEF    = 25,
  parameter int Y_DEF    = 3,
  parameter int R_DEF    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fsm_g,
  input  logic             fsm_y,
  input  logic             fsm_r,
  input  logic             hold,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             g_end,
  output logic             y_end,
  output logic             r_end,
  output logic [CNT_W-1:0] remain,
  output logic             tick_1s,
  output logic             phase_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [2:0]       phase_q, phase_d;
  logic [2:0]       end_q, end_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] g_dur_q, y_dur_q, r_dur_q;

  logic [2:0]       p;
  logic             onehot;
  logic [1:0]       p_idx;
  logic [CNT_W-1:0] cfg_clamp;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] ld_dur;

  assign p      = {fsm_g, fsm_y, fsm_r};
  assign onehot = (p == 3'b100) || (p == 3'b010) || (p == 3'b001);

  assign cfg_clamp = (cfg_data == '0) ? CNT_W'(1) : cfg_data;

  always_comb begin
    p_idx  = 2'd3;
    shadow = r_dur_q;
    if (fsm_g) begin
      p_idx  = 2'd0;
      shadow = g_dur_q;
    end else if (fsm_y) begin
      p_idx  = 2'd1;
      shadow = y_dur_q;
    end else if (fsm_r) begin
      p_idx  = 2'd2;
      shadow = r_dur_q;
    end
  end

  // A write landing on the load edge of the same phase is used immediately
  assign ld_dur = (cfg_we && cfg_sel == p_idx) ? cfg_clamp : shadow;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    end_d    = 3'b000;
    tick_d   = 1'b0;
    err_d    = !onehot;
    phase_d  = onehot ? p : 3'b000;
    if (!onehot) begin
      state_d  = S_IDLE;
      remain_d = '0;
      presc_d  = '0;
    end else if (p != phase_q) begin
      state_d  = S_RUN;
      remain_d = ld_dur;
      presc_d  = '0;
    end else if (state_q == S_RUN && !hold) begin
      if (presc_q == PMAX) begin
        presc_d  = '0;
        tick_d   = 1'b1;
        remain_d = remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) begin
          end_d   = phase_q;
          state_d = S_DONE;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      remain_q <= '0;
      phase_q  <= 3'b000;
      end_q    <= 3'b000;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      g_dur_q  <= CNT_W'(G_DEF);
      y_dur_q  <= CNT_W'(Y_DEF);
      r_dur_q  <= CNT_W'(R_DEF);
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      phase_q  <= phase_d;
      end_q    <= end_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      if (cfg_we && cfg_sel == 2'd0) g_dur_q <= cfg_clamp;
      if (cfg_we && cfg_sel == 2'd1) y_dur_q <= cfg_clamp;
      if (cfg_we && cfg_sel == 2'd2) r_dur_q <= cfg_clamp;
    end
  end

  assign g_end     = end_q[2];
  assign y_end     = end_q[1];
  assign r_end     = end_q[0];
  assign remain    = remain_q;
  assign tick_1s   = tick_q;
  assign phase_err = err_q;

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// Randomized closed-loop bench for phase_timer_ctrl with a
// work-remaining reference model and an end-pulse scoreboard.
module tb_phase_timer_ctrl;

  localparam int T  = 4;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fsm_g, fsm_y, fsm_r;
  logic          hold;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] cfg_data;
  logic          g_end, y_end, r_end;
  logic [CW-1:0] remain;
  logic          tick_1s;
  logic          phase_err;

  phase_timer_ctrl #(
    .TICK_DIV(T), .CNT_W(CW),
    .G_DEF(25), .Y_DEF(3), .R_DEF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fsm_g(fsm_g), .fsm_y(fsm_y), .fsm_r(fsm_r),
    .hold(hold), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .g_end(g_end), .y_end(y_end), .r_end(r_end),
    .remain(remain), .tick_1s(tick_1s),
    .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  // reference model: state expressed as cycles of work left
  int         sh [3];
  logic [2:0] m_ph;
  int         m_work;
  bit         m_run;
  int         exp_remain;
  bit         exp_tick;
  bit         exp_err;

  always @(posedge clk) begin
    logic [2:0] pv;
    int         idx, d, clamp;
    cyc++;
    pv    = {fsm_g, fsm_y, fsm_r};
    clamp = (cfg_data == 0) ? 1 : int'(cfg_data);
    if (!rst_n) begin
      sh[0] = 25; sh[1] = 3; sh[2] = 2;
      m_ph = 3'b000; m_work = 0; m_run = 0;
      exp_remain = 0; exp_tick = 0; exp_err = 0;
      q.delete();
    end else begin
      exp_tick = 0;
      exp_err  = !$onehot(pv);
      if (!$onehot(pv)) begin
        m_run = 0; m_work = 0; m_ph = 3'b000;
        exp_remain = 0;
      end else if (pv != m_ph) begin
        idx = pv[2] ? 0 : (pv[1] ? 1 : 2);
        d = (cfg_we && int'(cfg_sel) == idx) ? clamp : sh[idx];
        m_work = d * T; m_run = 1; m_ph = pv;
        exp_remain = d;
      end else if (m_run && !hold) begin
        m_work--;
        if (m_work % T == 0) exp_tick = 1;
        exp_remain = (m_work + T - 1) / T;
        if (m_work == 0) begin
          m_run = 0;
          q.push_back('{kind: m_ph, cyc: cyc});
        end
      end
      if (cfg_we && cfg_sel != 2'd3) sh[cfg_sel] = clamp;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [2:0] ends;
    ev_t        e;
    if (cyc >= 1) begin
      ends = {g_end, y_end, r_end};
      tests++;
      if (remain !== exp_remain[CW-1:0]) begin
        fails++;
        $display("FAIL remain cyc=%0d got=%0d exp=%0d",
                 cyc, remain, exp_remain);
      end
      tests++;
      if (tick_1s !== exp_tick) begin
        fails++;
        $display("FAIL tick_1s cyc=%0d got=%b exp=%b",
                 cyc, tick_1s, exp_tick);
      end
      tests++;
      if (phase_err !== exp_err) begin
        fails++;
        $display("FAIL phase_err cyc=%0d got=%b exp=%b",
                 cyc, phase_err, exp_err);
      end
      if (ends !== 3'b000) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL end_unexp cyc=%0d got=%b exp=none",
                   cyc, ends);
        end else begin
          e = q.pop_front();
          if (ends !== e.kind || cyc != e.cyc) begin
            fails++;
            $display("FAIL end_pulse cyc=%0d got=%b exp=%b@%0d",
                     cyc, ends, e.kind, e.cyc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        tests++;
        fails++;
        e = q.pop_front();
        $display("FAIL end_missing cyc=%0d got=000 exp=%b@%0d",
                 cyc, e.kind, e.cyc);
      end
    end
  end

  task automatic drive_raw(input logic [2:0] v);
    {fsm_g, fsm_y, fsm_r} = v;
  endtask

  task automatic drive(input int k);
    drive_raw({k == 0, k == 1, k == 2});
  endtask

  initial begin
    int cur, wait_n, err_left;
    rst_n = 1'b0; hold = 1'b0; cfg_we = 1'b0;
    cfg_sel = 2'd0; cfg_data = '0;
    drive_raw(3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cur = 2;
    drive(cur);
    // undisturbed red phase right after reset
    repeat (12) @(negedge clk);
    wait_n = -1;
    err_left = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      hold     = ($urandom_range(0, 9) == 0);
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_sel  = 2'($urandom_range(0, 3));
      cfg_data = CW'($urandom_range(0, 5));
      rst_n    = 1'b1;
      if (c == 1500 || c == 4200) begin
        rst_n = 1'b0;
        cur = 2;
        drive(cur);
        wait_n = -1;
        err_left = 0;
        continue;
      end
      if (err_left > 0) begin
        err_left--;
        if (err_left == 0) drive(cur);
        continue;
      end
      if (g_end || y_end || r_end) wait_n = $urandom_range(0, 3);
      if (wait_n == 0 || $urandom_range(0, 299) == 0) begin
        cur = (cur + 1) % 3;
        drive(cur);
        wait_n = -1;
      end else if (wait_n > 0) begin
        wait_n--;
      end
      if ($urandom_range(0, 399) == 0) begin
        err_left = $urandom_range(1, 3);
        drive_raw($urandom_range(0, 1) == 1 ? 3'b110 : 3'b000);
      end
    end
    hold = 1'b0;
    cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
